// File: rtl/mem_responder.sv
// ============================================================================
//  Module      : mem_responder
//  Description : Word-addressed unified instruction/data memory with a
//                request/ready handshake and a fixed number of wait states.
//                Optional MEM_BOUNDS_CHECK_EN flags out-of-range accesses.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_responder #(
  parameter int ADDR_BITS   = 10,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] MemoryAddress,
  input  logic [31:0] WriteDataMem,
  output logic [31:0] MemoryOut,
`ifdef MEM_BOUNDS_CHECK_EN
  output logic        MemErr,
`endif
  output logic        MemReady
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } stateType;

  localparam int         c_depth    = 2 ** ADDR_BITS;
  localparam logic [3:0] c_waitInit = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  stateType               r_state;
  stateType               w_nextState;
  logic [3:0]             r_waitCnt;
  logic [3:0]             w_nextWaitCnt;
  logic [ADDR_BITS-1:0]   r_addr;
  logic [31:0]            r_data;
  logic                   r_isWrite;
  logic                   r_isRead;
  logic [31:0]            r_mem [c_depth];

  logic                   w_req;
  logic                   w_enterResp;
  logic [ADDR_BITS-1:0]   w_accAddr;
  logic [31:0]            w_accData;
  logic                   w_accWrite;
  logic                   w_accRead;
  logic                   w_accOob;
  logic                   w_memWe;

  assign w_req = MemRead | MemWrite;

  // With zero wait states RESP is entered on the sampling edge itself, so the
  // access must be served from the live inputs while still in IDLE.
  assign w_accAddr  = (r_state == IDLE) ? MemoryAddress[ADDR_BITS-1:0] : r_addr;
  assign w_accData  = (r_state == IDLE) ? WriteDataMem : r_data;
  assign w_accWrite = (r_state == IDLE) ? MemWrite     : r_isWrite;
  assign w_accRead  = (r_state == IDLE) ? MemRead      : r_isRead;

`ifdef MEM_BOUNDS_CHECK_EN
  logic r_oob;
  assign w_accOob = (r_state == IDLE) ? (|MemoryAddress[31:ADDR_BITS]) : r_oob;
`else
  logic w_unusedAddrHi;
  assign w_unusedAddrHi = |MemoryAddress[31:ADDR_BITS];
  assign w_accOob       = 1'b0;
`endif

  assign w_enterResp = (w_nextState == RESP) && (r_state != RESP);
  assign w_memWe     = w_enterResp && w_accWrite && !w_accOob && !rst;

  always_comb begin
    w_nextState   = r_state;
    w_nextWaitCnt = r_waitCnt;
    MemReady      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          if (WAIT_STATES > 0) begin
            w_nextState   = WAIT;
            w_nextWaitCnt = c_waitInit;
          end else begin
            w_nextState = RESP;
          end
        end
      end
      WAIT: begin
        if (r_waitCnt == 4'd0) begin
          w_nextState = RESP;
        end else begin
          w_nextWaitCnt = r_waitCnt - 4'd1;
        end
      end
      RESP: begin
        MemReady    = 1'b1;
        w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_waitCnt <= 4'd0;
      r_addr    <= '0;
      r_data    <= 32'd0;
      r_isWrite <= 1'b0;
      r_isRead  <= 1'b0;
      MemoryOut <= 32'd0;
`ifdef MEM_BOUNDS_CHECK_EN
      r_oob     <= 1'b0;
      MemErr    <= 1'b0;
`endif
    end else begin
      r_state   <= w_nextState;
      r_waitCnt <= w_nextWaitCnt;
      if (r_state == IDLE && w_req) begin
        r_addr    <= MemoryAddress[ADDR_BITS-1:0];
        r_data    <= WriteDataMem;
        r_isWrite <= MemWrite;
        r_isRead  <= MemRead;
`ifdef MEM_BOUNDS_CHECK_EN
        r_oob     <= |MemoryAddress[31:ADDR_BITS];
`endif
      end
`ifdef MEM_BOUNDS_CHECK_EN
      MemErr <= w_enterResp && w_accOob;
`endif
      if (w_enterResp && w_accRead) begin
        if (w_accOob) begin
          MemoryOut <= 32'd0;
        end else if (w_accWrite) begin
          MemoryOut <= w_accData;
        end else begin
          MemoryOut <= r_mem[w_accAddr];
        end
      end
    end
  end

  // Array contents survive reset.
  always_ff @(posedge clk) begin
    if (w_memWe) begin
      r_mem[w_accAddr] <= w_accData;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder: one instance with two wait
// states, one with zero wait states.
`default_nettype none

module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd     [2];
  logic        wr     [2];
  logic [31:0] addr   [2];
  logic [31:0] wdata  [2];
  logic [31:0] memOut [2];
  logic        ready  [2];
`ifdef MEM_BOUNDS_CHECK_EN
  logic        err    [2];
`endif

  int nChecks = 0;
  int nFails  = 0;

  always #5 clk = ~clk;

  mem_responder #(.ADDR_BITS(10), .WAIT_STATES(2)) dutSlow (
    .clk           (clk),
    .rst           (rst),
    .MemRead       (rd[0]),
    .MemWrite      (wr[0]),
    .MemoryAddress (addr[0]),
    .WriteDataMem  (wdata[0]),
    .MemoryOut     (memOut[0]),
`ifdef MEM_BOUNDS_CHECK_EN
    .MemErr        (err[0]),
`endif
    .MemReady      (ready[0])
  );

  mem_responder #(.ADDR_BITS(10), .WAIT_STATES(0)) dutFast (
    .clk           (clk),
    .rst           (rst),
    .MemRead       (rd[1]),
    .MemWrite      (wr[1]),
    .MemoryAddress (addr[1]),
    .WriteDataMem  (wdata[1]),
    .MemoryOut     (memOut[1]),
`ifdef MEM_BOUNDS_CHECK_EN
    .MemErr        (err[1]),
`endif
    .MemReady      (ready[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic waitReady(input int d, output int lat, output logic [31:0] out, output logic errO);
    bit seen;
    seen = 1'b0;
    lat  = 0;
    out  = 32'd0;
    errO = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (ready[d]) begin
        seen = 1'b1;
        out  = memOut[d];
`ifdef MEM_BOUNDS_CHECK_EN
        errO = err[d];
`endif
      end
    end
    if (!seen) check("timeout", 32'd0, 32'd1);
  endtask

  task automatic doAccess(input int d, input logic r, input logic w, input logic [31:0] a,
                          input logic [31:0] dat, output int lat, output logic [31:0] out,
                          output logic errO);
    @(negedge clk);
    rd[d] = r; wr[d] = w; addr[d] = a; wdata[d] = dat;
    waitReady(d, lat, out, errO);
    rd[d] = 1'b0; wr[d] = 1'b0;
    @(posedge clk);
    #1;
    check("pulse", {31'd0, ready[d]}, 32'd0);
  endtask

  initial begin
    int          lat;
    logic [31:0] out;
    logic        e;

    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      rd[d] = 1'b0; wr[d] = 1'b0; addr[d] = 32'd0; wdata[d] = 32'd0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_out",   memOut[0], 32'd0);
    check("rst_ready", {31'd0, ready[0]}, 32'd0);

    // Zero wait states
    doAccess(1, 1'b0, 1'b1, 32'd0, 32'hA5A5A5A5, lat, out, e);
    check("ws0_wr_lat", lat, 1);
    doAccess(1, 1'b1, 1'b0, 32'd0, 32'd0, lat, out, e);
    check("ws0_rd_lat", lat, 1);
    check("ws0_rd_data", out, 32'hA5A5A5A5);
    doAccess(1, 1'b0, 1'b1, 32'd1, 32'h00000011, lat, out, e);
    doAccess(1, 1'b0, 1'b1, 32'd2, 32'h00000022, lat, out, e);

    // Back-to-back reads at a two-cycle period, MemRead held throughout
    @(negedge clk);
    rd[1] = 1'b1; addr[1] = 32'd0;
    for (int k = 0; k < 3; k++) begin
      logic [31:0] expB2b [3];
      expB2b[0] = 32'hA5A5A5A5; expB2b[1] = 32'h00000011; expB2b[2] = 32'h00000022;
      @(posedge clk); #1;
      check("b2b_ready", {31'd0, ready[1]}, 32'd1);
      check("b2b_data", memOut[1], expB2b[k]);
      addr[1] = 32'(k + 1);
      @(posedge clk); #1;
      check("b2b_gap", {31'd0, ready[1]}, 32'd0);
    end
    rd[1] = 1'b0;

    // Two wait states: latency and readback
    doAccess(0, 1'b0, 1'b1, 32'd3, 32'h12345678, lat, out, e);
    check("wr_lat", lat, 3);
    doAccess(0, 1'b1, 1'b0, 32'd3, 32'd0, lat, out, e);
    check("rd_lat", lat, 3);
    check("rd_data", out, 32'h12345678);

    // Reset mid-access abandons the write
    doAccess(0, 1'b0, 1'b1, 32'd5, 32'h11111111, lat, out, e);
    @(negedge clk);
    wr[0] = 1'b1; addr[0] = 32'd5; wdata[0] = 32'hDEADBEEF;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("rstmid_ready", {31'd0, ready[0]}, 32'd0);
    check("rstmid_out", memOut[0], 32'd0);
    @(negedge clk);
    rst = 1'b0; wr[0] = 1'b0;
    doAccess(0, 1'b1, 1'b0, 32'd5, 32'd0, lat, out, e);
    check("rstmid_lat", lat, 3);
    check("rstmid_data", out, 32'h11111111);

    // Simultaneous read/write is a write-through
    doAccess(0, 1'b1, 1'b1, 32'd7, 32'h000000FF, lat, out, e);
    check("rw_out", out, 32'h000000FF);
    doAccess(0, 1'b0, 1'b1, 32'd8, 32'h00000055, lat, out, e);
    check("wr_keeps_out", memOut[0], 32'h000000FF);
    doAccess(0, 1'b1, 1'b0, 32'd7, 32'd0, lat, out, e);
    check("rw_word", out, 32'h000000FF);

    // Address wrap / bounds check
    doAccess(0, 1'b0, 1'b1, 32'd0, 32'h0BADC0DE, lat, out, e);
    doAccess(0, 1'b0, 1'b1, 32'h400, 32'hCAFEF00D, lat, out, e);
    check("wrap_wr_lat", lat, 3);
`ifdef MEM_BOUNDS_CHECK_EN
    check("oob_wr_err", {31'd0, e}, 32'd1);
    doAccess(0, 1'b1, 1'b0, 32'd0, 32'd0, lat, out, e);
    check("oob_rd0_data", out, 32'h0BADC0DE);
    check("oob_rd0_err", {31'd0, e}, 32'd0);
    doAccess(0, 1'b1, 1'b0, 32'h400, 32'd0, lat, out, e);
    check("oob_rd_data", out, 32'd0);
    check("oob_rd_err", {31'd0, e}, 32'd1);
`else
    doAccess(0, 1'b1, 1'b0, 32'd0, 32'd0, lat, out, e);
    check("wrap_rd0", out, 32'hCAFEF00D);
    doAccess(0, 1'b1, 1'b0, 32'h400, 32'd0, lat, out, e);
    check("wrap_rd400", out, 32'hCAFEF00D);
`endif

    // Inputs changed mid-access have no effect
    doAccess(0, 1'b0, 1'b1, 32'd10, 32'h10101010, lat, out, e);
    @(negedge clk);
    wr[0] = 1'b1; addr[0] = 32'd9; wdata[0] = 32'hAAAA5555;
    @(posedge clk); #1;
    addr[0] = 32'd10; wdata[0] = 32'h00000001; wr[0] = 1'b0;
    waitReady(0, lat, out, e);
    check("mid_lat", lat + 1, 3);
    @(posedge clk); #1;
    doAccess(0, 1'b1, 1'b0, 32'd9, 32'd0, lat, out, e);
    check("mid_word9", out, 32'hAAAA5555);
    doAccess(0, 1'b1, 1'b0, 32'd10, 32'd0, lat, out, e);
    check("mid_word10", out, 32'h10101010);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Unified instruction/data memory that acts as the responder for the multicycle datapath's memory port.
- The datapath drives MemoryAddress and WriteDataMem and consumes MemoryOut; this block serves those accesses.
- Accesses are word-addressed, because the datapath increments PC by 1.
- A request/ready handshake with a programmable wait-state counter lets the control FSM stall for slow memory.

Parameters:
ADDR_BITS, 10, number of word-address bits used; depth = 2^ADDR_BITS words of 32 bits
WAIT_STATES, 2, extra cycles inserted before the response; 0..15 legal

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
MemRead  input  1  read request, held by initiator until MemReady
MemWrite  input  1  write request, held by initiator until MemReady
MemoryAddress  input  32  word address
WriteDataMem  input  32  write data
MemoryOut  output  32  read data, registered
MemReady  output  1  one-cycle completion pulse

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, wait counter=0, MemoryOut=0, MemReady=0.
  - Latched address, data and op cleared.
  - Memory array contents are not affected by reset.
  - Reset during WAIT or RESP abandons the access; a pending write is not committed.
- States: IDLE, WAIT, RESP.
- IDLE:
  - On an edge with MemRead|MemWrite=1, latch address[ADDR_BITS-1:0], WriteDataMem and op.
  - Next state: WAIT with counter=WAIT_STATES-1 if WAIT_STATES>0, otherwise RESP.
- WAIT:
  - Counter decrements every cycle; at counter==0 the next state is RESP.
  - Inputs are ignored; latched values are used.
- RESP:
  - MemReady=1 for exactly this one cycle.
  - Write: the array word is updated at the edge entering RESP.
  - Read: MemoryOut is loaded from the array at the edge entering RESP, so it is valid while MemReady=1.
  - Unconditional return to IDLE; requests are ignored in the RESP cycle.
- Latency: MemReady rises WAIT_STATES+1 cycles after the sampling edge. Back-to-back accesses occur every WAIT_STATES+2 cycles at best.
- MemoryOut holds its value until the next read completes. Writes do not change MemoryOut, except in the simultaneous read/write case below.
- Simultaneous MemRead=1 and MemWrite=1: treated as a write, and MemoryOut is loaded with the written data (write-through).
- Address wrap: upper address bits [31:ADDR_BITS] are ignored, so address 2^ADDR_BITS aliases word 0 (unless the optional feature is enabled).
- A request deasserted mid-access does not cancel it; the access completes as latched.

Optional Feature:
- Macro MEM_BOUNDS_CHECK_EN.
- When defined:
  - Adds output MemErr (1 bit, reset 0).
  - An access with any MemoryAddress[31:ADDR_BITS] bit set completes with normal timing.
  - MemErr=1 together with MemReady for that one cycle.
  - A write is suppressed (array unchanged); a read returns MemoryOut=32'h00000000.
- When undefined: no MemErr port, and addresses alias as described under Behaviour.

Test Plan:
- Reset mid-access: WAIT_STATES=2; write addr 5, data 32'hDEADBEEF; assert rst one cycle after the request is sampled; then read addr 5 -> MemReady pulses once; MemoryOut is the prior contents of word 5 (write not committed).
- Write/read latency: WAIT_STATES=2; write addr 3 = 32'h12345678 -> MemReady high exactly 3 cycles after the sampling edge, for 1 cycle. Then read addr 3 -> MemoryOut=32'h12345678 while MemReady=1.
- Zero wait: WAIT_STATES=0; read addr 0 after writing 32'hA5A5A5A5 -> MemReady on the 1st cycle after sampling. Back-to-back reads at a 2-cycle period return the correct data.
- Simultaneous request: MemRead=MemWrite=1, addr 7, data 32'h0000_00FF -> word 7=32'h000000FF and MemoryOut=32'h000000FF at MemReady.
- Wrap/aliasing: ADDR_BITS=10; write addr 32'h400 = 32'hCAFEF00D; read addr 0:
  - MEM_BOUNDS_CHECK_EN undefined -> MemoryOut=32'hCAFEF00D.
  - MEM_BOUNDS_CHECK_EN defined -> MemErr=1 on the write; a later read of addr 0 returns the old value; a read of addr 32'h400 gives MemoryOut=0 with MemErr=1.
- Mid-access input change: during WAIT, change MemoryAddress and WriteDataMem and drop MemWrite -> the originally latched address and data are written; the new values have no effect.
